// File: rtl/alu_pkg.sv
// Shared opcode and state definitions for the clocked ALU and its multiplier.
package alu_pkg;

    localparam int CMD_W = 4;

    typedef enum logic [CMD_W-1:0] {
        CMD_ADD   = 4'd0,
        CMD_SUB   = 4'd1,
        CMD_SHL   = 4'd2,
        CMD_ASR   = 4'd3,
        CMD_LSR   = 4'd4,
        CMD_NOT   = 4'd5,
        CMD_OR    = 4'd6,
        CMD_XOR   = 4'd7,
        CMD_AND   = 4'd8,
        CMD_PASSA = 4'd9,
        CMD_MUL   = 4'd10
    } alu_cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per clock.
// The first step happens on the start edge, so the product is ready WIDTH-1 edges later.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0]   count;
    logic               busy;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;

    // Conditionally add the multiplicand to the upper half, then shift the whole
    // register right; the multiplier bits drain out of the low half as it fills.
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
        logic [WIDTH:0] upper;
        // NOTE: blocking '=' is correct inside functions and always_comb; only
        // clocked state uses '<=' so every flop samples pre-edge values.
        upper = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        return {upper, p[WIDTH-1:1]};
    endfunction

    // NOTE: the operand/product registers are reset as well, so an aborted
    // multiply can never leak a partial product after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            busy  <= 1'b0;
            mcand <= '0;
            prod  <= '0;
        end else if (start) begin
            mcand <= a;
            prod  <= mul_step({{WIDTH{1'b0}}, b}, a);
            count <= CNT_W'(1);
            busy  <= 1'b1;
        end else if (busy) begin
            if (count == CNT_W'(WIDTH)) begin
                busy  <= 1'b0;
                count <= '0;
            end else begin
                prod  <= mul_step(prod, mcand);
                count <= count + CNT_W'(1);
            end
        end
    end

    assign done    = busy && (count == CNT_W'(WIDTH));
    assign product = prod;

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with valid/ready handshakes, registered flags and an iterative MUL.
// Single-cycle ops are computed combinationally from the offered operands and captured on accept.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] alu_cmd,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    input  logic             sc_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rslt,
    output logic [WIDTH-1:0] rslt_hi,
    output logic             sc_o,
    output logic             zero,
    output logic             pari
);

    state_e             state;
    alu_cmd_e           cmd;
    logic               accept;
    logic               start_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   n_rslt;
    logic               n_sc;

    assign cmd       = alu_cmd_e'(alu_cmd);
    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (cmd == CMD_MUL);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start_mul),
        .a       (inA),
        .b       (inB),
        .done    (mul_done),
        .product (mul_product)
    );

    // SUB reuses the adder with inverted inB; sc_o=1 then means "no borrow".
    always_comb begin
        // NOTE: defaults first so no path through the case can infer a latch.
        sum    = '0;
        n_rslt = '0;
        n_sc   = 1'b0;
        case (cmd)
            CMD_ADD: begin
                sum    = {1'b0, inA} + {1'b0, inB} + {{WIDTH{1'b0}}, sc_i};
                n_rslt = sum[WIDTH-1:0];
                n_sc   = sum[WIDTH];
            end
            CMD_SUB: begin
                sum    = {1'b0, inA} + {1'b0, ~inB} + {{WIDTH{1'b0}}, sc_i};
                n_rslt = sum[WIDTH-1:0];
                n_sc   = sum[WIDTH];
            end
            CMD_SHL: begin
                n_rslt = {inA[WIDTH-2:0], sc_i};
                n_sc   = inA[WIDTH-1];
            end
            CMD_ASR: begin
                n_rslt = {inA[WIDTH-1], inA[WIDTH-1:1]};
                n_sc   = inA[0];
            end
            CMD_LSR: begin
                n_rslt = {sc_i, inA[WIDTH-1:1]};
                n_sc   = inA[0];
            end
            CMD_NOT:   n_rslt = ~inA;
            CMD_OR:    n_rslt = inA | inB;
            CMD_XOR:   n_rslt = inA ^ inB;
            CMD_AND:   n_rslt = inA & inB;
            CMD_PASSA: n_rslt = inA;
            default: begin
                n_rslt = '0;
                n_sc   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            rslt      <= '0;
            rslt_hi   <= '0;
            sc_o      <= 1'b0;
            zero      <= 1'b1;
            pari      <= 1'b0;
        end else if (accept) begin
            // Accept is only possible in IDLE or in DONE while the old result retires.
            if (cmd == CMD_MUL) begin
                state     <= BUSY;
                out_valid <= 1'b0;
            end else begin
                state     <= DONE;
                out_valid <= 1'b1;
                rslt      <= n_rslt;
                rslt_hi   <= '0;
                sc_o      <= n_sc;
                zero      <= (n_rslt == '0);
                pari      <= ^n_rslt;
            end
        end else begin
            case (state)
                BUSY: begin
                    if (mul_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        rslt      <= mul_product[WIDTH-1:0];
                        rslt_hi   <= mul_product[2*WIDTH-1:WIDTH];
                        sc_o      <= |mul_product[2*WIDTH-1:WIDTH];
                        zero      <= (mul_product == '0);
                        pari      <= ^mul_product[WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: vector table for single-cycle ops plus MUL, stall and reset sequences.
module tb_seq_alu;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] cmd;
        logic [7:0] a;
        logic [7:0] b;
        logic       sc_i;
        logic [7:0] exp_rslt;
        logic       exp_sc;
        logic       exp_zero;
        logic       exp_pari;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid8 = 1'b0, out_ready8 = 1'b1, sc_i8 = 1'b0;
    logic [3:0]  cmd8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        in_ready8, out_valid8, sc_o8, zero8, pari8;
    logic [7:0]  rslt8, rslt_hi8;

    logic        in_valid16 = 1'b0, out_ready16 = 1'b1, sc_i16 = 1'b0;
    logic [3:0]  cmd16 = 4'd0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, sc_o16, zero16, pari16;
    logic [15:0] rslt16, rslt_hi16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(8), .CMD_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_cmd(cmd8), .inA(a8), .inB(b8), .sc_i(sc_i8), .out_valid(out_valid8),
        .out_ready(out_ready8), .rslt(rslt8), .rslt_hi(rslt_hi8), .sc_o(sc_o8),
        .zero(zero8), .pari(pari8)
    );

    seq_alu #(.WIDTH(16), .CMD_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_cmd(cmd16), .inA(a16), .inB(b16), .sc_i(sc_i16), .out_valid(out_valid16),
        .out_ready(out_ready16), .rslt(rslt16), .rslt_hi(rslt_hi16), .sc_o(sc_o16),
        .zero(zero16), .pari(pari16)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready8();
        int n = 0;
        while (!in_ready8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready8_timeout", 32'(in_ready8), 32'd1);
    endtask

    // Offer one single-cycle op, check the result the cycle after accept, then retire it.
    task automatic apply8(input vec_t v, input string tag);
        wait_ready8();
        cmd8 = v.cmd; a8 = v.a; b8 = v.b; sc_i8 = v.sc_i;
        in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        check({tag, ".valid"}, 32'(out_valid8), 32'd1);
        check({tag, ".rslt"},  32'(rslt8),      32'(v.exp_rslt));
        check({tag, ".hi"},    32'(rslt_hi8),   32'd0);
        check({tag, ".sc"},    32'(sc_o8),      32'(v.exp_sc));
        check({tag, ".zero"},  32'(zero8),      32'(v.exp_zero));
        check({tag, ".pari"},  32'(pari8),      32'(v.exp_pari));
        @(negedge clk);
    endtask

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{4'd1,  8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{4'd3,  8'h81, 8'h00, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd4,  8'h02, 8'h00, 1'b1, 8'h81, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd2,  8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{4'd0,  8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{4'd1,  8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{4'd1,  8'h00, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd5,  8'h0F, 8'h00, 1'b1, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'd6,  8'hA0, 8'h05, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'd7,  8'hFF, 8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd8,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd9,  8'h80, 8'h00, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{4'd12, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};

        // Reset values while held in reset
        #12;
        check("rst.valid",  32'(out_valid8), 32'd0);
        check("rst.ready",  32'(in_ready8),  32'd1);
        check("rst.rslt",   32'(rslt8),      32'd0);
        check("rst.hi",     32'(rslt_hi8),   32'd0);
        check("rst.sc",     32'(sc_o8),      32'd0);
        check("rst.zero",   32'(zero8),      32'd1);
        check("rst.pari",   32'(pari8),      32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply8(vecs[i], $sformatf("vec%0d", i));

        // MUL FF*FF: busy for 8 cycles; operand changes during BUSY are ignored
        wait_ready8();
        cmd8 = CMD_MUL; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1; out_ready8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0; a8 = 8'h12; b8 = 8'h34; cmd8 = CMD_ADD;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("mul8.busy_ready%0d", k), 32'(in_ready8),  32'd0);
            check($sformatf("mul8.busy_valid%0d", k), 32'(out_valid8), 32'd0);
            @(negedge clk);
        end
        check("mul8.valid", 32'(out_valid8), 32'd1);
        check("mul8.hi",    32'(rslt_hi8),   32'hFE);
        check("mul8.lo",    32'(rslt8),      32'h01);
        check("mul8.sc",    32'(sc_o8),      32'd1);
        check("mul8.zero",  32'(zero8),      32'd0);
        check("mul8.pari",  32'(pari8),      32'd1);
        @(negedge clk);

        // MUL 00*37: full product zero
        wait_ready8();
        cmd8 = CMD_MUL; a8 = 8'h00; b8 = 8'h37; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (8) @(negedge clk);
        check("mul8z.valid", 32'(out_valid8), 32'd1);
        check("mul8z.lo",    32'({rslt_hi8, rslt8}), 32'd0);
        check("mul8z.zero",  32'(zero8), 32'd1);
        check("mul8z.sc",    32'(sc_o8), 32'd0);
        @(negedge clk);

        // WIDTH=16: FFFF*0002 over 16 cycles
        cmd16 = CMD_MUL; a16 = 16'hFFFF; b16 = 16'h0002; in_valid16 = 1'b1;
        @(negedge clk);
        in_valid16 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("mul16.busy%0d", k), 32'({in_ready16, out_valid16}), 32'd0);
            @(negedge clk);
        end
        check("mul16.valid", 32'(out_valid16), 32'd1);
        check("mul16.hi",    32'(rslt_hi16),   32'h0001);
        check("mul16.lo",    32'(rslt16),      32'hFFFE);
        check("mul16.sc",    32'(sc_o16),      32'd1);
        check("mul16.zero",  32'(zero16),      32'd0);
        @(negedge clk);

        // Stall: ADD 01+02 held for 3 cycles with a pending offer, then 4 back-to-back ADDs
        wait_ready8();
        cmd8 = CMD_ADD; a8 = 8'h01; b8 = 8'h02; sc_i8 = 1'b0;
        in_valid8 = 1'b1; out_ready8 = 1'b0;
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall.valid%0d", k), 32'(out_valid8), 32'd1);
            check($sformatf("stall.rslt%0d", k),  32'(rslt8),      32'h03);
            check($sformatf("stall.ready%0d", k), 32'(in_ready8),  32'd0);
            if (k < 2) @(negedge clk);
        end
        out_ready8 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("b2b.valid%0d", k), 32'(out_valid8), 32'd1);
            check($sformatf("b2b.rslt%0d", k),  32'(rslt8),      32'(2 * k));
            if (k < 4) begin
                a8 = 8'(k + 1); b8 = 8'(k + 1);
            end else begin
                in_valid8 = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b.drain", 32'(out_valid8), 32'd0);

        // Reset 4 cycles into a MUL aborts it immediately
        cmd8 = CMD_MUL; a8 = 8'hFF; b8 = 8'hFF; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort.valid", 32'(out_valid8), 32'd0);
        check("abort.rslt",  32'({rslt_hi8, rslt8}), 32'd0);
        check("abort.flags", 32'({sc_o8, zero8, pari8}), 32'b010);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("abort.idle%0d", k), 32'({in_ready8, out_valid8}), 32'b10);
        end
        apply8('{4'd0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 1'b1}, "post_rst_add");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
